// File: rtl/alu_flag_unit_pkg.sv
// Shared definitions for the ALU flag stage: flag bit positions, flag_op
// encodings, FSM state codes and small op-classification helpers.
package alu_flag_unit_pkg;

    localparam int FLAG_L = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [2:0] {
        FLAG_OP_NOP   = 3'b000,
        FLAG_OP_CLL   = 3'b001,
        FLAG_OP_CPL   = 3'b010,
        FLAG_OP_STL   = 3'b011,
        FLAG_OP_ADD   = 3'b100,
        FLAG_OP_LOGIC = 3'b101,
        FLAG_OP_ROLL  = 3'b110,
        FLAG_OP_RSVD  = 3'b111
    } flag_op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ALU = 1'b1
    } state_e;

    // Ops that need an ALU result before they can be applied.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == FLAG_OP_ADD) || (op == FLAG_OP_LOGIC) || (op == FLAG_OP_ROLL);
    endfunction

    function automatic logic is_l_op(input logic [2:0] op);
        return (op == FLAG_OP_CLL) || (op == FLAG_OP_CPL) || (op == FLAG_OP_STL);
    endfunction

endpackage

// File: rtl/alu_flag_eval.sv
// Combinational next-flag evaluation: given an op, the ALU result and the
// current flags, produce the {V,Z,N,L} value the op would leave behind.
module alu_flag_eval
    import alu_flag_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_carry,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic [3:0]       flags_cur,
    output logic [3:0]       flags_next
);

    logic y_neg_s;
    logic y_zero_s;

    assign y_neg_s  = alu_y[WIDTH-1];
    assign y_zero_s = (alu_y == {WIDTH{1'b0}});

    // Per-op flag update; unlisted ops leave the flags untouched.
    always_comb begin
        flags_next = flags_cur;
        case (op)
            FLAG_OP_CLL: flags_next[FLAG_L] = 1'b0;
            FLAG_OP_CPL: flags_next[FLAG_L] = ~flags_cur[FLAG_L];
            FLAG_OP_STL: flags_next[FLAG_L] = 1'b1;
            FLAG_OP_ADD: begin
                flags_next[FLAG_L] = flags_cur[FLAG_L] ^ alu_carry;
                flags_next[FLAG_N] = y_neg_s;
                flags_next[FLAG_Z] = y_zero_s;
                flags_next[FLAG_V] = (a_msb == b_msb) && (y_neg_s != a_msb);
            end
            FLAG_OP_LOGIC: begin
                flags_next[FLAG_N] = y_neg_s;
                flags_next[FLAG_Z] = y_zero_s;
                flags_next[FLAG_V] = 1'b0;
            end
            FLAG_OP_ROLL: begin
                flags_next[FLAG_L] = alu_carry;
                flags_next[FLAG_N] = y_neg_s;
                flags_next[FLAG_Z] = y_zero_s;
            end
            default: flags_next = flags_cur;
        endcase
    end

endmodule

// File: rtl/alu_flag_unit.sv
// ALU flag stage: live L/N/Z/V registers, wait-for-ALU FSM with timeout,
// interrupt shadow save/restore and ibus read/write access.
module alu_flag_unit
    import alu_flag_unit_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int WAIT_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_carry,
    input  logic             alu_valid,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic [2:0]       flag_op,
    input  logic             int_entry,
    input  logic             int_exit,
    input  logic             w_flags,
    input  logic             r_flags,
    input  logic [WIDTH-1:0] ibus_in,
    output logic [WIDTH-1:0] ibus_out,
    output logic             l_out,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       pend_op_r;
    logic [3:0]       flags_r;
    logic [3:0]       shadow_r;
    logic             shadow_valid_r;
    logic             busy_r;
    logic             err_r;

    logic [2:0]       op_sel_s;
    logic             apply_s;
    logic [3:0]       flags_next_s;
    logic             unused_s;

    // Only the low nibble of the bus carries flag data.
    assign unused_s = ^ibus_in[WIDTH-1:4];

    alu_flag_eval #(.WIDTH(WIDTH)) u_eval (
        .op         (op_sel_s),
        .alu_y      (alu_y),
        .alu_carry  (alu_carry),
        .a_msb      (a_msb),
        .b_msb      (b_msb),
        .flags_cur  (flags_r),
        .flags_next (flags_next_s)
    );

    // Select the op being evaluated and decide whether it lands this cycle.
    always_comb begin
        op_sel_s = pend_op_r;
        apply_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            op_sel_s = flag_op;
            apply_s  = is_l_op(flag_op) || (is_alu_op(flag_op) && alu_valid);
        end else begin
            apply_s  = alu_valid;
        end
    end

    // Flag, shadow, error and wait-FSM state; interrupt events own the whole cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            pend_op_r      <= 3'b000;
            flags_r        <= 4'b0000;
            shadow_r       <= 4'b0000;
            shadow_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            err_r          <= 1'b0;
        end else if (int_entry) begin
            if (!shadow_valid_r) begin
                shadow_r       <= flags_r;
                shadow_valid_r <= 1'b1;
                flags_r        <= 4'b0000;
                state_r        <= ST_IDLE;
                cnt_r          <= {CNT_W{1'b0}};
                busy_r         <= 1'b0;
            end else begin
                err_r <= 1'b1;
            end
        end else if (int_exit) begin
            if (shadow_valid_r) begin
                flags_r        <= shadow_r;
                shadow_valid_r <= 1'b0;
            end else begin
                err_r <= 1'b1;
            end
        end else begin
            if (w_flags) begin
                flags_r <= ibus_in[3:0];
            end else if (apply_s) begin
                flags_r <= flags_next_s;
            end else begin
                flags_r <= flags_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (is_alu_op(flag_op) && !alu_valid) begin
                        pend_op_r <= flag_op;
                        cnt_r     <= {CNT_W{1'b0}};
                        state_r   <= ST_WAIT_ALU;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_WAIT_ALU: begin
                    if (alu_valid) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_W'(WAIT_MAX - 1)) begin
                        err_r   <= 1'b1;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Wired-OR bus contribution: zero unless this unit is being read.
    always_comb begin
        if (r_flags) begin
            ibus_out = {{(WIDTH-4){1'b0}}, flags_r};
        end else begin
            ibus_out = {WIDTH{1'b0}};
        end
    end

    assign flags = flags_r;
    assign l_out = flags_r[FLAG_L];
    assign busy  = busy_r;
    assign err   = err_r;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed scenarios plus randomized traffic for alu_flag_unit, checked
// cycle by cycle against a behavioural flag model.
module tb_alu_flag_unit;

    localparam int WIDTH    = 16;
    localparam int WAIT_MAX = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] alu_y;
    logic             alu_carry, alu_valid, a_msb, b_msb;
    logic [2:0]       flag_op;
    logic             int_entry, int_exit, w_flags, r_flags;
    logic [WIDTH-1:0] ibus_in;
    logic [WIDTH-1:0] ibus_out;
    logic             l_out, busy, err;
    logic [3:0]       flags;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    bit m_l, m_n, m_z, m_v;
    bit [3:0] m_shadow;
    bit m_saved, m_err, m_busy;
    int m_pend_op;
    int m_waited;

    alu_flag_unit #(.WIDTH(WIDTH), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .alu_y(alu_y), .alu_carry(alu_carry),
        .alu_valid(alu_valid), .a_msb(a_msb), .b_msb(b_msb), .flag_op(flag_op),
        .int_entry(int_entry), .int_exit(int_exit), .w_flags(w_flags),
        .r_flags(r_flags), .ibus_in(ibus_in), .ibus_out(ibus_out),
        .l_out(l_out), .flags(flags), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [3:0] m_flags();
        return {m_v, m_z, m_n, m_l};
    endfunction

    task automatic model_reset();
        {m_l, m_n, m_z, m_v} = 4'b0000;
        m_shadow = 4'b0000;
        m_saved = 1'b0; m_err = 1'b0; m_busy = 1'b0;
        m_pend_op = 0; m_waited = 0;
    endtask

    // Effect of an op on the flags, written from the op definitions.
    task automatic model_apply(input int op);
        bit res_neg, res_zero;
        res_neg  = (alu_y >= 16'h8000);
        res_zero = (alu_y == 16'd0);
        case (op)
            1: m_l = 1'b0;
            2: m_l = !m_l;
            3: m_l = 1'b1;
            4: begin
                if (alu_carry) m_l = !m_l;
                m_n = res_neg; m_z = res_zero;
                // overflow: operands share a sign that the result lost
                if (a_msb == b_msb && res_neg != a_msb) m_v = 1'b1; else m_v = 1'b0;
            end
            5: begin m_n = res_neg; m_z = res_zero; m_v = 1'b0; end
            6: begin m_l = alu_carry; m_n = res_neg; m_z = res_zero; end
            default: ;
        endcase
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit do_apply;
        int op;
        do_apply = 1'b0;
        op = 0;
        if (reset) begin
            model_reset();
        end else if (int_entry) begin
            if (!m_saved) begin
                m_shadow = m_flags(); m_saved = 1'b1;
                {m_v, m_z, m_n, m_l} = 4'b0000;
                m_busy = 1'b0;
            end else m_err = 1'b1;
        end else if (int_exit) begin
            if (m_saved) begin
                {m_v, m_z, m_n, m_l} = m_shadow; m_saved = 1'b0;
            end else m_err = 1'b1;
        end else begin
            if (!m_busy) begin
                op = int'(flag_op);
                if (op >= 1 && op <= 3) do_apply = 1'b1;
                else if (op >= 4 && op <= 6) begin
                    if (alu_valid) do_apply = 1'b1;
                    else begin m_busy = 1'b1; m_pend_op = op; m_waited = 0; end
                end
            end else begin
                op = m_pend_op;
                if (alu_valid) begin do_apply = 1'b1; m_busy = 1'b0; end
                else begin
                    m_waited++;
                    if (m_waited == WAIT_MAX) begin m_err = 1'b1; m_busy = 1'b0; end
                end
            end
            if (w_flags) {m_v, m_z, m_n, m_l} = ibus_in[3:0];
            else if (do_apply) model_apply(op);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".flags"}, WIDTH'(flags), WIDTH'(m_flags()));
        check_val({tag, ".l_out"}, WIDTH'(l_out), WIDTH'(m_l));
        check_val({tag, ".busy"},  WIDTH'(busy),  WIDTH'(m_busy));
        check_val({tag, ".err"},   WIDTH'(err),   WIDTH'(m_err));
        check_val({tag, ".ibus"},  ibus_out, r_flags ? WIDTH'(m_flags()) : 16'h0000);
    endtask

    // Called at a falling edge with inputs already driven for this cycle.
    task automatic tick(input string tag);
        #1;
        check_outputs(tag);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; alu_y = 16'h0000; alu_carry = 1'b0; alu_valid = 1'b0;
        a_msb = 1'b0; b_msb = 1'b0; flag_op = 3'b000; int_entry = 1'b0;
        int_exit = 1'b0; w_flags = 1'b0; r_flags = 1'b0; ibus_in = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        do_reset();
        r_flags = 1'b1;
        #1;
        check_val("rst.flags", WIDTH'(flags), 16'h0000);
        check_val("rst.busy",  WIDTH'(busy),  16'h0000);
        check_val("rst.err",   WIDTH'(err),   16'h0000);
        check_val("rst.ibus",  ibus_out,      16'h0000);
        r_flags = 1'b0;

        // ADD with result in the same cycle
        flag_op = 3'b100; alu_valid = 1'b1; alu_y = 16'h0000; alu_carry = 1'b1;
        a_msb = 1'b1; b_msb = 1'b1;
        tick("add_now");
        idle_inputs();
        #1 check_val("add_now.vznl", WIDTH'(flags), 16'h000D);

        // ROLL whose result arrives two cycles later
        flag_op = 3'b110;
        tick("roll_issue");
        idle_inputs();
        tick("roll_w0");
        alu_valid = 1'b1; alu_y = 16'h8001; alu_carry = 1'b0;
        tick("roll_w1");
        idle_inputs();
        #1 check_val("roll.vznl", WIDTH'(flags), 16'h000A);
        check_val("roll.busy", WIDTH'(busy), 16'h0000);

        // ADD that never sees alu_valid
        flag_op = 3'b100;
        tick("to_issue");
        idle_inputs();
        repeat (WAIT_MAX) tick("to_wait");
        #1 check_val("to.err", WIDTH'(err), 16'h0001);
        check_val("to.busy", WIDTH'(busy), 16'h0000);
        check_val("to.flags", WIDTH'(flags), 16'h000A);

        // Interrupt save / nested entry / restore
        do_reset();
        w_flags = 1'b1; ibus_in = 16'hFFF5;
        tick("wf");
        idle_inputs(); int_entry = 1'b1;
        tick("ie1");
        #1 check_val("ie1.flags", WIDTH'(flags), 16'h0000);
        tick("ie2");
        idle_inputs();
        #1 check_val("ie2.err", WIDTH'(err), 16'h0001);
        int_exit = 1'b1;
        tick("ix");
        idle_inputs();
        #1 check_val("ix.flags", WIDTH'(flags), 16'h0005);

        // STL with a same-cycle read, then CPL
        w_flags = 1'b1; ibus_in = 16'h0000;
        tick("clr");
        idle_inputs(); flag_op = 3'b011; r_flags = 1'b1;
        #1 check_val("stl.same", ibus_out, 16'h0000);
        tick("stl");
        flag_op = 3'b000;
        #1 check_val("stl.next", ibus_out, 16'h0001);
        idle_inputs(); flag_op = 3'b010;
        tick("cpl");
        idle_inputs();
        #1 check_val("cpl.l", WIDTH'(l_out), 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(99) == 0);
            int_entry = ($urandom_range(15) == 0);
            int_exit  = ($urandom_range(15) == 0);
            w_flags   = ($urandom_range(7) == 0);
            r_flags   = $urandom_range(1);
            alu_valid = ($urandom_range(2) == 0);
            alu_carry = $urandom_range(1);
            a_msb     = $urandom_range(1);
            b_msb     = $urandom_range(1);
            flag_op   = 3'($urandom_range(7));
            ibus_in   = 16'($urandom);
            case ($urandom_range(3))
                0: alu_y = 16'h0000;
                1: alu_y = 16'h8000;
                default: alu_y = 16'($urandom);
            endcase
            tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
